// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Iterative RV64M multiply/divide unit. It executes MUL, MULH, MULHSU, MULHU,
// DIV, DIVU, REM and REMU, plus the 32-bit word variants. It sits beside the
// single-cycle ALU. One radix-2 step is done per clock: shift-add for multiply,
// restoring shift-subtract for divide. The core works on unsigned magnitudes.
// Signs are applied on the clock that completes the operation.
//
// Latency, counted from the accept edge E0:
//   normal operations : out_valid rises at E0+W+1
//                       (W steps, then one edge to finalise the result)
//   divide-by-zero and signed overflow : out_valid rises at E0+1
//
// Parameters
//   XLEN      datapath width, 32 or 64
//   ENABLE_W  1: the word input is honoured (only when XLEN=64)
//             0: the word input is ignored
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous abort. It overrides in_valid and out_ready, and it
//              leaves result unchanged.
//   in_valid   request valid
//   in_ready   request handshake; high only when the unit is idle and not flushed
//   op         000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM,    111 REMU
//   word       W operation on the low 32 bits; result sign-extended from bit 31
//   src1       multiplicand / dividend
//   src2       multiplier / divisor
//   out_valid  result valid; held until out_ready is sampled high
//   out_ready  consumer takes the result
//   result     registered result; kept until the next operation completes
// -----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int XLEN     = 64,
  parameter bit ENABLE_W = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  // Word operations only exist on a 64-bit datapath.
  localparam bit            W_OK     = ENABLE_W && (XLEN == 64);
  localparam int            CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0] CNT_WORD = CW'(32);
  localparam int            WSH      = XLEN - 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = v[31];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v[31:0];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  //   acc  : multiply -> running 2W-bit product
  //          divide   -> partial remainder, kept in the low XLEN bits
  //          special  -> the final value, kept in the low XLEN bits
  //   areg : multiply -> multiplicand, shifted left each step
  //          divide   -> divisor, in the low XLEN bits
  //   breg : multiply -> multiplier, shifted right each step
  //          divide   -> dividend shifted out at the top while quotient bits
  //                      enter at the bottom
  // ---------------------------------------------------------------------------
  state_t              state;
  logic [CW-1:0]       count;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   areg;
  logic [XLEN-1:0]     breg;
  logic                neg_q;      // product sign or quotient sign
  logic                rneg_q;     // remainder sign (follows the dividend)
  logic                div_q;
  logic                rem_sel_q;
  logic                mul_low_q;
  logic                word_q;
  logic                special_q;

  // ---------------------------------------------------------------------------
  // Request decode: signedness, operand extension, magnitudes, special cases
  // ---------------------------------------------------------------------------
  logic            word_eff;
  logic            is_div;
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_ext, b_ext;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] min_val;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;

  // NOTE: every signal driven here gets a default at the top of the block, so
  // no path can leave one unassigned and infer a latch.
  always_comb begin
    word_eff    = word & W_OK;
    is_div      = op[2];
    a_sgn       = 1'b0;
    b_sgn       = 1'b0;
    a_ext       = src1;
    b_ext       = src2;
    min_val     = '0;
    special_val = '0;

    if (is_div) begin
      a_sgn = ~op[0];
      b_sgn = ~op[0];
    end else if (word_eff) begin
      // MULHW/MULHSUW/MULHUW are reserved encodings and execute as MULW.
      // Only low bits are kept, so signed/signed is as good as any choice.
      a_sgn = 1'b1;
      b_sgn = 1'b1;
    end else begin
      a_sgn = (op[1:0] != 2'b11);   // MULHU is the only mul op with src1 unsigned
      b_sgn = ~op[1];               // MULHSU and MULHU take src2 unsigned
    end

    if (word_eff) begin
      a_ext   = a_sgn ? sext32(src1) : zext32(src1);
      b_ext   = b_sgn ? sext32(src2) : zext32(src2);
      min_val = sext32(XLEN'(32'h8000_0000));
    end else begin
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end

    a_neg = a_sgn & a_ext[XLEN-1];
    b_neg = b_sgn & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & ~op[0] & (a_ext == min_val) & (&b_ext);
    special  = div_zero | div_ovf;

    // Special results are computed at accept time.
    // For word ops the final sign-extension from bit 31 is applied later.
    if (div_zero) special_val = op[1] ? a_ext : '1;
    else if (div_ovf) special_val = op[1] ? '0 : a_ext;
  end

  assign in_ready = (state == S_IDLE) && !flush;

  // ---------------------------------------------------------------------------
  // Iteration step and finalisation
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin, fin_ext;
  logic              last;

  always_comb begin
    rem_sh = {acc[XLEN-1:0], breg[XLEN-1]};
    diff   = rem_sh - {1'b0, areg[XLEN-1:0]};
    prod_s = neg_q ? -acc : acc;
    quo_s  = neg_q ? -breg : breg;
    rem_s  = rneg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    last   = (count == (word_q ? CNT_WORD : CNT_FULL));
    fin    = '0;

    if (special_q) fin = acc[XLEN-1:0];
    else if (div_q) fin = rem_sel_q ? rem_s : quo_s;
    else if (mul_low_q) fin = prod_s[XLEN-1:0];
    else fin = prod_s[2*XLEN-1:XLEN];

    fin_ext = word_q ? sext32(fin) : fin;
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments. Every register then
  // samples the pre-edge value of every other register, whatever the
  // statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      acc       <= '0;
      areg      <= '0;
      breg      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      div_q     <= 1'b0;
      rem_sel_q <= 1'b0;
      mul_low_q <= 1'b0;
      word_q    <= 1'b0;
      special_q <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      // Abort: the in-flight operands are left in place, but the next accept
      // overwrites all of them and result is not touched.
      state     <= S_IDLE;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            state     <= S_BUSY;
            count     <= '0;
            div_q     <= is_div;
            rem_sel_q <= op[1];
            mul_low_q <= word_eff | (op[1:0] == 2'b00);
            word_q    <= word_eff;
            special_q <= special;
            neg_q     <= a_neg ^ b_neg;
            rneg_q    <= a_neg;
            areg      <= {{XLEN{1'b0}}, is_div ? b_mag : a_mag};
            if (special) begin
              acc  <= {{XLEN{1'b0}}, special_val};
              breg <= '0;
            end else begin
              acc <= '0;
              // Dividend bits must leave breg MSB-first, starting from bit W-1.
              if (is_div) breg <= word_eff ? (a_mag << WSH) : a_mag;
              else breg <= b_mag;
            end
          end
        end

        S_BUSY: begin
          if (special_q || last) begin
            result    <= fin_ext;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            count <= count + CW'(1);
            if (div_q) begin
              // Restoring step: keep the difference only if it did not borrow.
              acc  <= {{XLEN{1'b0}}, diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]};
              breg <= {breg[XLEN-2:0], ~diff[XLEN]};
            end else begin
              if (breg[0]) acc <= acc + areg;
              areg <= areg << 1;
              breg <= breg >> 1;
            end
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            count     <= '0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
